// File: rtl/sdram_auto_refresh_pkg.sv
// Shared definitions for the SDRAM auto-refresh engine: command encodings,
// address width, default timing and the FSM state type.
package sdram_auto_refresh_pkg;

    localparam int ASIZE          = 13;
    localparam int REF_PERIOD_DEF = 780;
    localparam int TRP_CLK_DEF    = 2;
    localparam int TRC_CLK_DEF    = 7;
    localparam int A10            = 10;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_PRE      = 3'd2,
        ST_WAIT_TRP = 3'd3,
        ST_AREF     = 3'd4,
        ST_WAIT_TRC = 3'd5,
        ST_DONE     = 3'd6
    } ref_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_auto_refresh_timer.sv
// Refresh interval timer: counts REF_PERIOD clocks while init_done is high and
// raises pending on each wrap; a wrap that finds pending still set flags overrun.
module sdram_ref_timer #(
    parameter int REF_PERIOD = 780
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic init_done,
    input  logic clr_pending,
    output logic pending,
    output logic overrun
);
    localparam int CNT_W = $clog2(REF_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             wrap;

    always_comb begin
        wrap      = init_done && (cnt_q == CNT_W'(REF_PERIOD - 1));
        cnt_d     = '0;
        pending_d = 1'b0;
        overrun_d = overrun_q;
        if (init_done) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            // A new period outranks a grant landing on the same edge.
            if (wrap)
                pending_d = 1'b1;
            else if (clr_pending)
                pending_d = 1'b0;
            else
                pending_d = pending_q;
            if (wrap && pending_q && !clr_pending)
                overrun_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/sdram_auto_refresh.sv
// Periodic AUTO REFRESH engine: PRECHARGE ALL then AUTO REFRESH on each grant.
// Build option SDRAM_REF_DOUBLE_EN issues a second AREF/tRC pair per request.
module sdram_auto_refresh
    import sdram_auto_refresh_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF,
    parameter int TRP_CLK    = TRP_CLK_DEF,
    parameter int TRC_CLK    = TRC_CLK_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             init_done,
    input  logic             ref_en,
    output logic             ref_req,
    output logic             ref_done,
    output logic             ref_overrun,
    output logic [3:0]       command,
    output logic [ASIZE-1:0] saddr,
    output logic [2:0]       state_dbg
);
    localparam int DLY_W = $clog2(max_int(TRP_CLK, TRC_CLK) + 1);

    ref_state_e       state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             ref_req_q, ref_req_d;
    logic             ref_done_q, ref_done_d;
    logic [3:0]       command_q, command_d;
    logic [ASIZE-1:0] saddr_q, saddr_d;
    logic             pending;
    logic             clr_pending;
`ifdef SDRAM_REF_DOUBLE_EN
    logic             second_q, second_d;
`endif

    sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_timer (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .init_done   (init_done),
        .clr_pending (clr_pending),
        .pending     (pending),
        .overrun     (ref_overrun)
    );

    // Handshake: ref_req stays high in REQ until ref_en is sampled high on an
    // edge; that edge is the grant, drops ref_req and clears pending.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        ref_req_d   = 1'b0;
        ref_done_d  = 1'b0;
        command_d   = CMD_NOP;
        saddr_d     = '0;
        clr_pending = 1'b0;
`ifdef SDRAM_REF_DOUBLE_EN
        second_d    = second_q;
`endif
        if (!init_done) begin
            state_d = ST_IDLE;
            dly_d   = '0;
`ifdef SDRAM_REF_DOUBLE_EN
            second_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending) begin
                        state_d   = ST_REQ;
                        ref_req_d = 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ref_en) begin
                        state_d     = ST_PRE;
                        clr_pending = 1'b1;
                    end else begin
                        ref_req_d = 1'b1;
                    end
                end
                ST_PRE: begin
                    command_d    = CMD_PRECHARGE;
                    saddr_d[A10] = 1'b1;
                    dly_d        = DLY_W'(TRP_CLK - 1);
                    state_d      = ST_WAIT_TRP;
                end
                ST_WAIT_TRP: begin
                    if (dly_q == '0) state_d = ST_AREF;
                    else             dly_d   = dly_q - 1'b1;
                end
                ST_AREF: begin
                    command_d = CMD_AREF;
                    dly_d     = DLY_W'(TRC_CLK - 1);
                    state_d   = ST_WAIT_TRC;
                end
                ST_WAIT_TRC: begin
                    if (dly_q == '0) begin
`ifdef SDRAM_REF_DOUBLE_EN
                        if (!second_q) begin
                            state_d  = ST_AREF;
                            second_d = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        dly_d = dly_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    ref_done_d = 1'b1;
                    state_d    = ST_IDLE;
`ifdef SDRAM_REF_DOUBLE_EN
                    second_d   = 1'b0;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            dly_q      <= '0;
            ref_req_q  <= 1'b0;
            ref_done_q <= 1'b0;
            command_q  <= CMD_NOP;
            saddr_q    <= '0;
`ifdef SDRAM_REF_DOUBLE_EN
            second_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            ref_req_q  <= ref_req_d;
            ref_done_q <= ref_done_d;
            command_q  <= command_d;
            saddr_q    <= saddr_d;
`ifdef SDRAM_REF_DOUBLE_EN
            second_q   <= second_d;
`endif
        end
    end

    assign ref_req   = ref_req_q;
    assign ref_done  = ref_done_q;
    assign command   = command_q;
    assign saddr     = saddr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sdram_auto_refresh.sv
// Bench for sdram_auto_refresh: fixed refresh-sequence table, hand-written
// corner sequences and a randomized run against a command-list reference model.
module tb_sdram_auto_refresh;
    import sdram_auto_refresh_pkg::*;

    localparam int P   = REF_PERIOD_DEF;
    localparam int TRP = TRP_CLK_DEF;
    localparam int TRC = TRC_CLK_DEF;
`ifdef SDRAM_REF_DOUBLE_EN
    localparam int DONE_IDX = 1 + 1 + TRP + 2 * (1 + TRC);
`else
    localparam int DONE_IDX = 1 + 1 + TRP + 1 + TRC;
`endif
    localparam int TBL_LEN  = DONE_IDX + 2;
    localparam logic [ASIZE-1:0] SADDR_A10 = ASIZE'(1) << A10;

    // ---------------- clock / reset ----------------
    logic             CLK = 1'b0;
    logic             RST_N;
    logic             init_done;
    logic             ref_en;
    logic             ref_req;
    logic             ref_done;
    logic             ref_overrun;
    logic [3:0]       command;
    logic [ASIZE-1:0] saddr;
    logic [2:0]       state_dbg;

    always #5 CLK = ~CLK;

    sdram_auto_refresh #(
        .REF_PERIOD (P),
        .TRP_CLK    (TRP),
        .TRC_CLK    (TRC)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .init_done   (init_done),
        .ref_en      (ref_en),
        .ref_req     (ref_req),
        .ref_done    (ref_done),
        .ref_overrun (ref_overrun),
        .command     (command),
        .saddr       (saddr),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic req, input logic done, input logic ovr,
                                         input logic [3:0] cmd, input logic [ASIZE-1:0] sa);
        return 32'({req, done, ovr, cmd, sa});
    endfunction

    function automatic logic [31:0] dut_vec();
        return pack(ref_req, ref_done, ref_overrun, command, saddr);
    endfunction

    // ---------------- reference model ----------------
    // A refresh is a list of bus commands replayed one per clock after the
    // grant, followed by one ref_done cycle.
    logic [3:0] seq_q[$];
    int   m_timer;
    bit   m_pending, m_overrun, m_req, m_done;
    int   m_mode;   // 0 waiting for interval, 1 requesting, 2 replaying commands
    int   m_idx;
    logic [3:0]       m_cmd;
    logic [ASIZE-1:0] m_saddr;

    task automatic build_seq();
        seq_q.delete();
        seq_q.push_back(CMD_PRECHARGE);
        repeat (TRP) seq_q.push_back(CMD_NOP);
        seq_q.push_back(CMD_AREF);
        repeat (TRC) seq_q.push_back(CMD_NOP);
`ifdef SDRAM_REF_DOUBLE_EN
        seq_q.push_back(CMD_AREF);
        repeat (TRC) seq_q.push_back(CMD_NOP);
`endif
    endtask

    task automatic model_reset();
        m_timer = 0; m_pending = 0; m_overrun = 0; m_req = 0; m_done = 0;
        m_mode = 0; m_idx = 0; m_cmd = CMD_NOP; m_saddr = '0;
    endtask

    task automatic model_step(input bit id, input bit en);
        bit wrap, grant, p_old;
        m_cmd = CMD_NOP; m_saddr = '0; m_done = 0; m_req = 0;
        if (!id) begin
            m_timer = 0; m_pending = 0; m_mode = 0;
            return;
        end
        p_old = m_pending;
        wrap  = (m_timer == P - 1);
        grant = (m_mode == 1) && en;
        if (wrap && p_old && !grant) m_overrun = 1;
        if (wrap)       m_pending = 1;
        else if (grant) m_pending = 0;
        m_timer = (m_timer + 1) % P;
        case (m_mode)
            0: if (p_old) begin m_mode = 1; m_req = 1; end
            1: if (en) begin m_mode = 2; m_idx = 0; end else m_req = 1;
            default: begin
                if (m_idx < seq_q.size()) begin
                    m_cmd = seq_q[m_idx];
                    if (m_cmd == CMD_PRECHARGE) m_saddr = SADDR_A10;
                    m_idx++;
                end else begin
                    m_done = 1;
                    m_mode = 0;
                end
            end
        endcase
    endtask

    // ---------------- driver ----------------
    // Inputs change at the falling edge; outputs are sampled at the next one.
    task automatic step(input bit id, input bit en);
        init_done = id;
        ref_en    = en;
        @(posedge CLK);
        model_step(id, en);
        exp_q.push_back(pack(m_req, m_done, m_overrun, m_cmd, m_saddr));
        @(negedge CLK);
    endtask

    typedef struct {
        bit               en;
        logic             req;
        logic             done;
        logic [3:0]       cmd;
        logic [ASIZE-1:0] sa;
    } vec_t;

    vec_t tbl[TBL_LEN];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, cnt_done, cnt_pre, drop_cnt, en_pct;
        logic [31:0] e;

        // expected refresh sequence from the cycle after ref_req is seen
        for (int k = 0; k < TBL_LEN; k++) begin
            tbl[k].en   = (k == 0) ? 1'b1 : bit'(k % 2);
            tbl[k].req  = 1'b0;
            tbl[k].done = (k == DONE_IDX);
            tbl[k].cmd  = CMD_NOP;
            tbl[k].sa   = '0;
        end
        tbl[1].cmd = CMD_PRECHARGE;
        tbl[1].sa  = SADDR_A10;
        tbl[1 + 1 + TRP].cmd = CMD_AREF;
`ifdef SDRAM_REF_DOUBLE_EN
        tbl[1 + 1 + TRP + 1 + TRC].cmd = CMD_AREF;
`endif

        build_seq();
        model_reset();
        RST_N = 1'b0; init_done = 1'b0; ref_en = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", dut_vec(), pack(0, 0, 0, CMD_NOP, '0));
        check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        RST_N = 1'b1;

        // init_done low: nothing happens regardless of ref_en
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            if (ref_req !== 1'b0 || command !== CMD_NOP) bad++;
        end
        check("idle_while_not_init", 32'(bad), 32'd0);

        // first request latency, then the fixed command table
        n = 0;
        do begin step(1'b1, 1'b1); n++; end while (ref_req !== 1'b1 && n < 2000);
        check("first_req_latency", 32'(n), 32'd781);
        for (int k = 0; k < TBL_LEN; k++) begin
            step(1'b1, tbl[k].en);
            check($sformatf("seq_row%0d", k), dut_vec(),
                  pack(tbl[k].req, tbl[k].done, 1'b0, tbl[k].cmd, tbl[k].sa));
        end

        // periodic repeat
        n = 1;
        do begin step(1'b1, 1'b1); n++; end while (ref_done !== 1'b1 && n < 2000);
        check("done_period", 32'(n), 32'(P));

        // starved grant: request holds, overrun sets, one refresh on grant
        n = 0;
        do begin step(1'b1, 1'b0); n++; end while (ref_req !== 1'b1 && n < 1000);
        check("starve_req_seen", 32'(ref_req), 32'd1);
        bad = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b1, 1'b0);
            if (ref_req !== 1'b1) bad++;
        end
        check("req_held", 32'(bad), 32'd0);
        check("overrun_set", 32'(ref_overrun), 32'd1);
        cnt_done = 0; cnt_pre = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1);
            if (ref_done === 1'b1) cnt_done++;
            if (command === CMD_PRECHARGE) cnt_pre++;
        end
        check("one_refresh_done", 32'(cnt_done), 32'd1);
        check("one_refresh_pre", 32'(cnt_pre), 32'd1);

        // init_done dropped inside WAIT_TRC
        n = 0;
        do begin step(1'b1, 1'b1); n++; end while (ref_req !== 1'b1 && n < 1000);
        repeat (1 + 1 + 1 + TRP + 1 + 1) step(1'b1, 1'b1);
        check("in_wait_trc", 32'(state_dbg), 32'(ST_WAIT_TRC));
        step(1'b0, 1'b1);
        check("drop_outputs", dut_vec(), pack(0, 0, 1, CMD_NOP, '0));
        check("drop_state", 32'(state_dbg), 32'(ST_IDLE));
        cnt_done = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            if (ref_done === 1'b1) cnt_done++;
        end
        check("drop_no_done", 32'(cnt_done), 32'd0);
        n = 0;
        do begin step(1'b1, 1'b1); n++; end while (ref_req !== 1'b1 && n < 2000);
        check("reraise_latency", 32'(n), 32'd781);

        // asynchronous reset in WAIT_TRP
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("in_wait_trp", 32'(state_dbg), 32'(ST_WAIT_TRP));
        #2 RST_N = 1'b0;
        #1;
        check("async_reset_outputs", dut_vec(), pack(0, 0, 0, CMD_NOP, '0));
        check("async_reset_state", 32'(state_dbg), 32'(ST_IDLE));
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;

        // randomized run against the model
        exp_q.delete();
        drop_cnt = 0;
        en_pct = 20;
        for (int i = 0; i < 15000; i++) begin
            bit id;
            if (i % 1000 == 0) begin
                case ($urandom_range(0, 3))
                    0: en_pct = 0;
                    1: en_pct = 3;
                    2: en_pct = 30;
                    default: en_pct = 100;
                endcase
            end
            if (drop_cnt > 0) begin
                id = 1'b0;
                drop_cnt--;
            end else begin
                id = 1'b1;
                if ($urandom_range(0, 1499) == 0) drop_cnt = $urandom_range(1, 5);
            end
            step(id, ($urandom_range(0, 99) < en_pct));
            e = exp_q.pop_front();
            check($sformatf("rand_cycle%0d", i), dut_vec(), e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
